// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state enumeration and round primitives.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // a..h (or H0..H7); a / H0 occupies the top 32 bits
    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } wv_t;

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_e;

    localparam wv_t IV_256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam wv_t IV_224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                              32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic wv_t sha_round(input wv_t s, input word_t k, input word_t w);
        word_t t1, t2;
        wv_t   r;
        t1  = s.h + bsig1(s.e) + ch(s.e, s.f, s.g) + k + w;
        t2  = bsig0(s.a) + maj(s.a, s.b, s.c);
        r.a = t1 + t2;
        r.b = s.a;
        r.c = s.b;
        r.d = s.c;
        r.e = s.d + t1;
        r.f = s.e;
        r.g = s.f;
        r.h = s.g;
        return r;
    endfunction

    function automatic wv_t add_state(input wv_t x, input wv_t y);
        wv_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message window; presents W[t..t+UNROLL-1] for the current round group.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     adv_i,
    input  logic [511:0]             blk_i,
    output logic [UNROLL-1:0][31:0]  w_o
);

    word_t win_q [16];
    word_t win_d [16];
    word_t ext   [16+UNROLL];

    // Later new words may depend on earlier new words of the same cycle (UNROLL=4)
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = win_q[i];
        for (int j = 0; j < UNROLL; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];

        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
        if (load_i) begin
            for (int i = 0; i < 16; i++) win_d[i] = blk_i[511-32*i -: 32];
        end else if (adv_i) begin
            for (int i = 0; i < 16; i++) win_d[i] = ext[i+UNROLL];
        end
    end

    always_comb begin
        for (int j = 0; j < UNROLL; j++) w_o[j] = win_q[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 compression core: one 512-bit block per accept, UNROLL rounds per clock.
// Define SHA224_EN to add the mode_224 port (SHA-224 IV, H7 forced to zero in the digest).
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int UNROLL    = 1,
    parameter bit BYTE_SWAP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic [511:0] blk_data,
`ifdef SHA224_EN
    input  logic         mode_224,
`endif
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha256_compress_core: UNROLL must be 1, 2 or 4");
    end

    localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);
    localparam logic [5:0] CNT_STEP = 6'(UNROLL);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    wv_t         wv_q, wv_d;
    wv_t         h_q, h_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        dv_q, dv_d;
    logic        accept, advance;
    wv_t         iv_new, iv_base;
    logic [UNROLL-1:0][31:0] w_cur;
    wv_t         chain [UNROLL+1];

`ifdef SHA224_EN
    logic mode_q, hmode_q;

    // mode follows the chain from its first block; hmode tracks what H currently holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            hmode_q <= 1'b0;
        end else begin
            if (accept && blk_first) mode_q  <= mode_224;
            if (state_q == UPDATE)   hmode_q <= mode_q;
        end
    end

    assign iv_new  = mode_224 ? IV_224 : IV_256;
    assign iv_base = mode_q   ? IV_224 : IV_256;
`else
    assign iv_new  = IV_256;
    assign iv_base = IV_256;
`endif

    sha256_msg_schedule #(.UNROLL(UNROLL)) u_sched (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .adv_i  (advance),
        .blk_i  (blk_data),
        .w_o    (w_cur)
    );

    always_comb begin
        chain[0] = wv_q;
        for (int j = 0; j < UNROLL; j++)
            chain[j+1] = sha_round(chain[j], K[cnt_q + 6'(j)], w_cur[j]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wv_d    = wv_q;
        h_d     = h_q;
        first_d = first_q;
        last_d  = last_q;
        dv_d    = 1'b0;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                    cnt_d   = '0;
                    first_d = blk_first;
                    last_d  = blk_last;
                    wv_d    = blk_first ? iv_new : h_q;
                end
            end
            ROUND: begin
                advance = 1'b1;
                wv_d    = chain[UNROLL];
                cnt_d   = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) state_d = UPDATE;
            end
            UPDATE: begin
                h_d     = add_state(first_q ? iv_base : h_q, wv_q);
                dv_d    = last_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wv_q    <= '0;
            h_q     <= IV_256;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
            h_q     <= h_d;
            first_q <= first_d;
            last_q  <= last_d;
            dv_q    <= dv_d;
        end
    end

    assign blk_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign digest_valid = dv_q;

    logic [255:0] h_vec;
    assign h_vec = h_q;

    always_comb begin
        digest = '0;
        for (int i = 0; i < 8; i++) begin
            if (BYTE_SWAP)
                digest[255-32*i -: 32] = {h_vec[255-32*i-24 -: 8], h_vec[255-32*i-16 -: 8],
                                          h_vec[255-32*i-8 -: 8],  h_vec[255-32*i -: 8]};
            else
                digest[255-32*i -: 32] = h_vec[255-32*i -: 32];
        end
`ifdef SHA224_EN
        if (hmode_q) digest[31:0] = '0;
`endif
    end

endmodule
